// File: rtl/updown_counter.sv
// updown_counter
//   Parametrised up/down counter over the range 0..MAX_VAL with wrap or
//   saturate behaviour at the range ends, synchronous clear and clamped load,
//   and a registered Gray-coded copy of the count that is always in step with
//   the binary count. Typical uses: FIFO read/write pointers, occupancy
//   tracking, general modulo counting.
//
// Parameters
//   WIDTH     counter width in bits (>= 2)
//   MAX_VAL   terminal count, must fit in WIDTH bits
//   SATURATE  0 = wrap at range ends, 1 = hold at range ends
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous reset, active-high
//   i_clr         synchronous clear to 0
//   i_load        load i_load_val (clamped to MAX_VAL)
//   i_load_val    value to load
//   i_up          count up by one (ignored when i_down is also high)
//   i_down        count down by one (ignored when i_up is also high)
//   o_count       registered count
//   o_count_gray  registered Gray code of o_count
//   o_wrap        one-cycle pulse: the last update wrapped (SATURATE=0)
//   o_sat         one-cycle pulse: the last step was blocked (SATURATE=1)
//   o_at_max      o_count == MAX_VAL
//   o_at_zero     o_count == 0

module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_up,
  input  logic             i_down,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_count_gray,
  output logic             o_wrap,
  output logic             o_sat,
  output logic             o_at_max,
  output logic             o_at_zero
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  // A terminal count that does not fit in WIDTH bits would silently truncate,
  // so refuse to elaborate instead.
  if (MAX_VAL >= (1 << WIDTH)) begin : g_max_val_check
    $error("updown_counter: MAX_VAL (%0d) does not fit in WIDTH (%0d) bits",
           MAX_VAL, WIDTH);
  end

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;
  logic             next_sat;
  logic             step_up;
  logic             step_down;

  // Exactly one of up/down must be asserted to step; both or neither holds.
  assign step_up   = i_up & ~i_down;
  assign step_down = i_down & ~i_up;

  // Next-state selection in priority order clear > load > step. Reset is
  // applied in the register so it overrides everything chosen here.
  always_comb begin
    next_count = o_count;
    next_wrap  = 1'b0;
    next_sat   = 1'b0;
    if (i_clr) begin
      next_count = '0;
    end else if (i_load) begin
      next_count = (i_load_val > MAX_CNT) ? MAX_CNT : i_load_val;
    end else if (step_up) begin
      if (o_count == MAX_CNT) begin
        if (SATURATE) begin
          next_sat = 1'b1;
        end else begin
          next_count = '0;
          next_wrap  = 1'b1;
        end
      end else begin
        next_count = o_count + WIDTH'(1);
      end
    end else if (step_down) begin
      if (o_count == '0) begin
        if (SATURATE) begin
          next_sat = 1'b1;
        end else begin
          next_count = MAX_CNT;
          next_wrap  = 1'b1;
        end
      end else begin
        next_count = o_count - WIDTH'(1);
      end
    end
  end

  // The Gray copy is encoded from next_count and registered alongside the
  // binary count, so both change on the same edge with no skew.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_count      <= '0;
      o_count_gray <= '0;
      o_wrap       <= 1'b0;
      o_sat        <= 1'b0;
    end else begin
      o_count      <= next_count;
      o_count_gray <= next_count ^ (next_count >> 1);
      o_wrap       <= next_wrap;
      o_sat        <= next_sat;
    end
  end

  assign o_at_max  = (o_count == MAX_CNT);
  assign o_at_zero = (o_count == '0);

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter
//   Directed bench driving three counter instances from one shared stimulus:
//   d0 = (WIDTH 4, MAX 9, wrap), d1 = (WIDTH 4, MAX 9, saturate),
//   d2 = (WIDTH 4, MAX 15, wrap). Each step applies inputs, waits one rising
//   edge, then checks the outputs 1 ns later against hand-written values.

module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       up;
  logic       down;

  logic [3:0] cnt0, gray0, cnt1, gray1, cnt2, gray2;
  logic       wrap0, sat0, amax0, azero0;
  logic       wrap1, sat1, amax1, azero1;
  logic       wrap2, sat2, amax2, azero2;

  logic [11:0] obs0, obs1, obs2;

  int vectors     = 0;
  int miscompares = 0;

  // Hand-written 4-bit Gray codes for 0..15.
  logic [3:0] gray_tab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  // Expected counts for twelve up steps from reset.
  logic [3:0] up_exp0 [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
  logic [3:0] up_exp1 [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9};
  logic [3:0] up_exp2 [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12};

  logic [3:0] prev_gray;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) d0 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_up(up), .i_down(down), .o_count(cnt0), .o_count_gray(gray0),
    .o_wrap(wrap0), .o_sat(sat0), .o_at_max(amax0), .o_at_zero(azero0)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) d1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_up(up), .i_down(down), .o_count(cnt1), .o_count_gray(gray1),
    .o_wrap(wrap1), .o_sat(sat1), .o_at_max(amax1), .o_at_zero(azero1)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) d2 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr), .i_load(load), .i_load_val(load_val),
    .i_up(up), .i_down(down), .o_count(cnt2), .o_count_gray(gray2),
    .o_wrap(wrap2), .o_sat(sat2), .o_at_max(amax2), .o_at_zero(azero2)
  );

  assign obs0 = {cnt0, gray0, wrap0, sat0, amax0, azero0};
  assign obs1 = {cnt1, gray1, wrap1, sat1, amax1, azero1};
  assign obs2 = {cnt2, gray2, wrap2, sat2, amax2, azero2};

  // Drive one cycle of inputs, let one rising edge take them, then settle.
  task automatic apply_stimulus(input logic r, input logic c, input logic l,
                                input logic [3:0] v, input logic u,
                                input logic d);
    rst      = r;
    clr      = c;
    load     = l;
    load_val = v;
    up       = u;
    down     = d;
    @(posedge clk);
    #1;
  endtask

  // Compare one instance's packed outputs against an expected count/pulses.
  task automatic check_output(input string tag, input logic [11:0] obs,
                              input logic [3:0] cnt, input logic wrap,
                              input logic sat, input logic [3:0] maxv);
    logic [11:0] exp_v;
    exp_v = {cnt, gray_tab[cnt], wrap, sat, (cnt == maxv), (cnt == 4'd0)};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed cnt=%0d gray=%b wrap=%b sat=%b max=%b zero=%b, expected cnt=%0d gray=%b wrap=%b sat=%b max=%b zero=%b",
             tag, obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
             exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
    end
  endtask

  // Linear sequence of directed steps.
  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = 4'd0; up = 1'b0; down = 1'b0;

    // Reset state
    apply_stimulus(1, 0, 0, 4'd0, 0, 0);
    check_output("reset_d0", obs0, 4'd0, 0, 0, 4'd9);
    check_output("reset_d1", obs1, 4'd0, 0, 0, 4'd9);
    check_output("reset_d2", obs2, 4'd0, 0, 0, 4'd15);

    // Twelve up steps: d0 wraps once, d1 saturates at 9, d2 just counts
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(0, 0, 0, 4'd0, 1, 0);
      check_output($sformatf("up%0d_d0", i), obs0, up_exp0[i], (i == 9), 0, 4'd9);
      check_output($sformatf("up%0d_d1", i), obs1, up_exp1[i], 0, (i >= 9), 4'd9);
      check_output($sformatf("up%0d_d2", i), obs2, up_exp2[i], 0, 0, 4'd15);
    end

    // Down twice from zero
    apply_stimulus(1, 0, 0, 4'd0, 0, 0);
    apply_stimulus(0, 0, 0, 4'd0, 0, 1);
    check_output("dn0_d0", obs0, 4'd9, 1, 0, 4'd9);
    check_output("dn0_d1", obs1, 4'd0, 0, 1, 4'd9);
    check_output("dn0_d2", obs2, 4'd15, 1, 0, 4'd15);
    apply_stimulus(0, 0, 0, 4'd0, 0, 1);
    check_output("dn1_d0", obs0, 4'd8, 0, 0, 4'd9);
    check_output("dn1_d1", obs1, 4'd0, 0, 1, 4'd9);
    check_output("dn1_d2", obs2, 4'd14, 1'b0, 0, 4'd15);

    // Loads: clamp above MAX, exact boundary, and load beats a step
    apply_stimulus(0, 0, 1, 4'd13, 0, 0);
    check_output("ld13_d0", obs0, 4'd9, 0, 0, 4'd9);
    check_output("ld13_d2", obs2, 4'd13, 0, 0, 4'd15);
    apply_stimulus(0, 0, 1, 4'd10, 0, 0);
    check_output("ld10_d1", obs1, 4'd9, 0, 0, 4'd9);
    check_output("ld10_d2", obs2, 4'd10, 0, 0, 4'd15);
    apply_stimulus(0, 0, 1, 4'd9, 0, 0);
    check_output("ld9_d0", obs0, 4'd9, 0, 0, 4'd9);
    apply_stimulus(0, 0, 1, 4'd4, 1, 0);
    check_output("ldup_d0", obs0, 4'd4, 0, 0, 4'd9);
    check_output("ldup_d1", obs1, 4'd4, 0, 0, 4'd9);

    // Holds, clear priority, and reset dominating everything
    apply_stimulus(0, 0, 1, 4'd5, 0, 0);
    apply_stimulus(0, 0, 0, 4'd0, 1, 1);
    check_output("both_d0", obs0, 4'd5, 0, 0, 4'd9);
    check_output("both_d2", obs2, 4'd5, 0, 0, 4'd15);
    apply_stimulus(0, 0, 0, 4'd0, 0, 0);
    check_output("idle_d1", obs1, 4'd5, 0, 0, 4'd9);
    apply_stimulus(0, 1, 1, 4'd7, 0, 0);
    check_output("clrld_d0", obs0, 4'd0, 0, 0, 4'd9);
    check_output("clrld_d2", obs2, 4'd0, 0, 0, 4'd15);
    apply_stimulus(0, 0, 0, 4'd0, 0, 1);
    check_output("prerst_d0", obs0, 4'd9, 1, 0, 4'd9);
    check_output("prerst_d1", obs1, 4'd0, 0, 1, 4'd9);
    apply_stimulus(1, 1, 1, 4'd7, 1, 0);
    check_output("rstall_d0", obs0, 4'd0, 0, 0, 4'd9);
    check_output("rstall_d1", obs1, 4'd0, 0, 0, 4'd9);
    check_output("rstall_d2", obs2, 4'd0, 0, 0, 4'd15);

    // Full Gray sequence on the MAX=15 instance, one bit change per step
    for (int i = 0; i < 16; i++) begin
      prev_gray = gray2;
      apply_stimulus(0, 0, 0, 4'd0, 1, 0);
      check_output($sformatf("gray%0d_d2", i), obs2, 4'((i + 1) % 16), (i == 15), 0, 4'd15);
      vectors++;
      assert ($countones(prev_gray ^ gray2) == 1) else begin
        miscompares++;
        $error("[TB] FAIL gray_onebit%0d: observed %b -> %b, expected exactly one bit change",
               i, prev_gray, gray2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
